attempt_lockout: RTL and testbench

// Downstream of the password-entry FSM: consumes its per-attempt result pulses.

---
 rtl/attempt_lockout.sv | 140 ++++++++++++++
 tb/tb_attempt_lockout.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/attempt_lockout.sv
// Consecutive-failure lockout behind the password-entry FSM: counts wrong attempts,
// locks for LOCK_SECS ticks or opens for UNLOCK_SECS ticks, and shows the remaining ticks on two 7-seg digits.
module attempt_lockout #(
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_SECS   = 30,
    parameter int UNLOCK_SECS = 5
) (
    input  logic       clk_div,
    input  logic       rst,
    input  logic       pass_evt,
    input  logic       fail_evt,
    output logic       locked,
    output logic       unlocked,
    output logic [2:0] fail_cnt,
    output logic [6:0] HEX_T,
    output logic [6:0] HEX_U
);

    generate
        if (MAX_FAILS < 1 || MAX_FAILS > 7) begin : g_bad_max_fails
            $error("attempt_lockout: MAX_FAILS must be in 1..7");
        end
        if (LOCK_SECS < 1 || LOCK_SECS > 99) begin : g_bad_lock_secs
            $error("attempt_lockout: LOCK_SECS must be in 1..99");
        end
        if (UNLOCK_SECS < 1 || UNLOCK_SECS > 99) begin : g_bad_unlock_secs
            $error("attempt_lockout: UNLOCK_SECS must be in 1..99");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_OPEN    = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

    // BCD load values are elaboration-time constants, so no runtime divider exists.
    localparam logic [2:0] FAIL_MAX  = 3'(MAX_FAILS);
    localparam logic [2:0] FAIL_LAST = 3'(MAX_FAILS - 1);
    localparam logic [3:0] LOCK_T    = 4'(LOCK_SECS / 10);
    localparam logic [3:0] LOCK_U    = 4'(LOCK_SECS % 10);
    localparam logic [3:0] OPEN_T    = 4'(UNLOCK_SECS / 10);
    localparam logic [3:0] OPEN_U    = 4'(UNLOCK_SECS % 10);

    state_t     r_state;
    logic [2:0] r_fail_cnt;
    logic [3:0] r_tens;
    logic [3:0] r_units;

    state_t     w_state_next;
    logic [2:0] w_fail_cnt_next;
    logic [3:0] w_tens_next;
    logic [3:0] w_units_next;
    logic       w_show;

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            r_state    <= ST_ARMED;
            r_fail_cnt <= 3'd0;
            r_tens     <= 4'd0;
            r_units    <= 4'd0;
        end else begin
            r_state    <= w_state_next;
            r_fail_cnt <= w_fail_cnt_next;
            r_tens     <= w_tens_next;
            r_units    <= w_units_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_fail_cnt_next = r_fail_cnt;
        w_tens_next     = r_tens;
        w_units_next    = r_units;
        case (r_state)
            ST_ARMED: begin
                if (fail_evt) begin
                    if (r_fail_cnt == FAIL_LAST) begin
                        w_state_next    = ST_LOCKED;
                        w_fail_cnt_next = FAIL_MAX;
                        w_tens_next     = LOCK_T;
                        w_units_next    = LOCK_U;
                    end else begin
                        w_fail_cnt_next = r_fail_cnt + 3'd1;
                    end
                end else if (pass_evt) begin
                    w_state_next    = ST_OPEN;
                    w_fail_cnt_next = 3'd0;
                    w_tens_next     = OPEN_T;
                    w_units_next    = OPEN_U;
                end
            end
            ST_OPEN, ST_LOCKED: begin
                // Events are ignored here; only the countdown advances.
                if (r_tens == 4'd0 && r_units == 4'd1) begin
                    w_state_next    = ST_ARMED;
                    w_fail_cnt_next = 3'd0;
                    w_tens_next     = 4'd0;
                    w_units_next    = 4'd0;
                end else if (r_units == 4'd0) begin
                    w_units_next = 4'd9;
                    w_tens_next  = r_tens - 4'd1;
                end else begin
                    w_units_next = r_units - 4'd1;
                end
            end
            default: begin
                w_state_next    = ST_ARMED;
                w_fail_cnt_next = 3'd0;
                w_tens_next     = 4'd0;
                w_units_next    = 4'd0;
            end
        endcase
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    assign w_show   = (r_state == ST_OPEN) || (r_state == ST_LOCKED);
    assign locked   = (r_state == ST_LOCKED);
    assign unlocked = (r_state == ST_OPEN);
    assign fail_cnt = r_fail_cnt;
    assign HEX_U    = w_show ? seg7(r_units) : 7'h7F;
    assign HEX_T    = (w_show && r_tens != 4'd0) ? seg7(r_tens) : 7'h7F;

endmodule

// File: tb/tb_attempt_lockout.sv
// Directed bench for attempt_lockout with default parameters (3 fails, 30 s lock, 5 s open).
module tb_attempt_lockout;

    logic       clk_div = 1'b0;
    logic       rst;
    logic       pass_evt;
    logic       fail_evt;
    logic       locked;
    logic       unlocked;
    logic [2:0] fail_cnt;
    logic [6:0] HEX_T;
    logic [6:0] HEX_U;

    int n_checks = 0;
    int n_pass   = 0;
    int n_step   = 0;

    attempt_lockout #(
        .MAX_FAILS  (3),
        .LOCK_SECS  (30),
        .UNLOCK_SECS(5)
    ) dut (
        .clk_div (clk_div),
        .rst     (rst),
        .pass_evt(pass_evt),
        .fail_evt(fail_evt),
        .locked  (locked),
        .unlocked(unlocked),
        .fail_cnt(fail_cnt),
        .HEX_T   (HEX_T),
        .HEX_U   (HEX_U)
    );

    always #5 clk_div = ~clk_div;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: seg = 7'h40;  1: seg = 7'h79;  2: seg = 7'h24;  3: seg = 7'h30;
            4: seg = 7'h19;  5: seg = 7'h12;  6: seg = 7'h02;  7: seg = 7'h78;
            8: seg = 7'h00;  9: seg = 7'h10;
            default: seg = 7'h7F;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    // One clk_div edge with the given event pulses; outputs sampled 1 ns after the edge.
    task automatic step(input logic p, input logic f);
        @(negedge clk_div);
        pass_evt = p;
        fail_evt = f;
        @(posedge clk_div);
        #1;
        pass_evt = 1'b0;
        fail_evt = 1'b0;
        n_step++;
        $display("step %0d pass=%0b fail=%0b -> locked=%0b unlocked=%0b fail_cnt=%0d HEX_T=%h HEX_U=%h",
                 n_step, p, f, locked, unlocked, fail_cnt, HEX_T, HEX_U);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_locked"},   {7'd0, locked},   8'h00);
        check({tag, "_unlocked"}, {7'd0, unlocked}, 8'h00);
        check({tag, "_fail_cnt"}, {5'd0, fail_cnt}, 8'h00);
        check({tag, "_hex_t"},    {1'b0, HEX_T},    8'h7F);
        check({tag, "_hex_u"},    {1'b0, HEX_U},    8'h7F);
    endtask

    task automatic check_count(input string tag, input int r, input logic is_lock);
        check({tag, "_locked"},   {7'd0, locked},   {7'd0, is_lock});
        check({tag, "_unlocked"}, {7'd0, unlocked}, {7'd0, ~is_lock});
        check({tag, "_hex_t"},    {1'b0, HEX_T},    {1'b0, (r >= 10) ? seg(r / 10) : 7'h7F});
        check({tag, "_hex_u"},    {1'b0, HEX_U},    {1'b0, seg(r % 10)});
    endtask

    initial begin
        rst      = 1'b1;
        pass_evt = 1'b0;
        fail_evt = 1'b0;
        #12;
        check_reset_vals("reset");
        @(negedge clk_div);
        rst = 1'b0;

        // Three fails at edges 1, 3, 5 lock for 30 cycles.
        step(0, 1); check("t1_cnt1", {5'd0, fail_cnt}, 8'd1);
        step(0, 0);
        step(0, 1); check("t1_cnt2", {5'd0, fail_cnt}, 8'd2);
        check("t1_notlocked", {7'd0, locked}, 8'd0);
        step(0, 0);
        step(0, 1);
        check_count("t1_lock30", 30, 1'b1);
        check("t1_cnt3", {5'd0, fail_cnt}, 8'd3);
        for (int r = 29; r >= 1; r--) begin
            step(0, 0);
            check_count("t1_countdown", r, 1'b1);
            if (r == 9) begin
                check("t5_borrow_t", {1'b0, HEX_T}, 8'h7F);
                check("t5_borrow_u", {1'b0, HEX_U}, 8'h10);
            end
        end
        step(0, 0);
        check_reset_vals("t1_release");

        // fail, fail, pass opens for 5 cycles; the later fail counts from zero.
        step(0, 1);
        step(0, 0);
        step(0, 1); check("t2_cnt2", {5'd0, fail_cnt}, 8'd2);
        step(1, 0);
        check_count("t2_open5", 5, 1'b0);
        check("t2_hex_t", {1'b0, HEX_T}, 8'h7F);
        check("t2_hex_u", {1'b0, HEX_U}, 8'h12);
        check("t2_cnt0", {5'd0, fail_cnt}, 8'd0);
        for (int r = 4; r >= 1; r--) begin
            step(0, 0);
            check_count("t2_open", r, 1'b0);
        end
        step(0, 0);
        check("t2_closed", {7'd0, unlocked}, 8'd0);
        step(0, 1);
        check("t2_cnt1", {5'd0, fail_cnt}, 8'd1);
        check("t2_never_locked", {7'd0, locked}, 8'd0);

        // Simultaneous pass+fail at fail_cnt=2: fail wins.
        step(0, 1); check("t3_cnt2", {5'd0, fail_cnt}, 8'd2);
        step(1, 1);
        check_count("t3_lock", 30, 1'b1);
        check("t3_cnt3", {5'd0, fail_cnt}, 8'd3);

        // Events during lockout are ignored; release after exactly 30 cycles.
        for (int r = 29; r >= 1; r--) begin
            step(r[0], ~r[0]);
            check_count("t4_ignore", r, 1'b1);
            check("t4_cnt3", {5'd0, fail_cnt}, 8'd3);
        end
        step(1, 1);
        check_reset_vals("t4_release");
        step(0, 0);

        // Async reset mid-lockout at remaining=17.
        step(0, 1); step(0, 1); step(0, 1);
        check_count("t6_lock", 30, 1'b1);
        for (int r = 29; r >= 17; r--) step(0, 0);
        check_count("t6_at17", 17, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("t6_async_rst");
        @(negedge clk_div);
        rst = 1'b0;
        step(0, 1);
        check("t6_cnt1", {5'd0, fail_cnt}, 8'd1);
        check("t6_not_locked", {7'd0, locked}, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
